// File: rtl/sequence_matcher_nch.sv
// rtl/sequence_matcher_nch.sv - multi-channel masked serial sequence matcher with hit counters
module sequence_matcher_nch #(
  parameter int WIDTH       = 8,
  parameter int NCH         = 4,
  parameter int CNT_W       = 16,
  parameter int NON_OVERLAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             flush,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_en,
  input  logic [2:0]       cnt_sel,
  input  logic             cnt_clr,
  output logic [NCH-1:0]   hit,
  output logic             hit_any,
  output logic [2:0]       hit_idx,
  output logic [CNT_W-1:0] cnt_q
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int BLK_W  = $clog2(WIDTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
  localparam logic [BLK_W-1:0]  BLK_LOAD = BLK_W'(WIDTH - 1);

  logic [WIDTH-2:0]  history;
  logic [FILL_W-1:0] fill_cnt;
  logic [WIDTH-1:0]  pattern [NCH];
  logic [WIDTH-1:0]  mask    [NCH];
  logic [NCH-1:0]    en;
  logic [BLK_W-1:0]  blk_cnt [NCH];
  logic [CNT_W-1:0]  hit_cnt [NCH];

  logic [WIDTH-1:0]  window;
  logic              filled;
  logic [NCH-1:0]    match;
  logic [2:0]        match_idx;
  logic [CNT_W-1:0]  cnt_sel_val;

  // The current bit counts toward the fill, so a full window is reached on the WIDTH-th valid bit.
  assign window = {history, sin};
  assign filled = (32'(fill_cnt) + 32'd1) >= WIDTH;

  // Per-channel compare of the live window; a flushed bit never matches.
  always_comb begin
    match = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sin_valid && !flush && filled && en[c] && (blk_cnt[c] == '0) &&
          (((window ^ pattern[c]) & mask[c]) == '0)) begin
        match[c] = 1'b1;
      end
    end
  end

  // Lowest matching channel wins the index; zero when nothing matched.
  always_comb begin
    match_idx = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (match[c]) match_idx = 3'(c);
    end
  end

  // Counter read mux; selects beyond the channel count read as zero.
  always_comb begin
    cnt_sel_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (32'(cnt_sel) == c) cnt_sel_val = hit_cnt[c];
    end
  end

  // Window history and fill level, advanced only by valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history  <= '0;
      fill_cnt <= '0;
    end else if (flush) begin
      history  <= '0;
      fill_cnt <= '0;
    end else if (sin_valid) begin
      history <= window[WIDTH-2:0];
      if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + FILL_W'(1);
    end
  end

  // Channel configuration; writes to nonexistent channels fall through the loop untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        pattern[c] <= '0;
        mask[c]    <= '1;
        en[c]      <= 1'b0;
      end
    end else if (cfg_we) begin
      for (int c = 0; c < NCH; c++) begin
        if (32'(cfg_ch) == c) begin
          pattern[c] <= cfg_pattern;
          mask[c]    <= cfg_mask;
          en[c]      <= cfg_en;
        end
      end
    end
  end

  // Non-overlap blocking: after a hit the channel sits out the next WIDTH-1 valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) blk_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cfg_we && (32'(cfg_ch) == c)) begin
          blk_cnt[c] <= '0;
        end else if (flush) begin
          blk_cnt[c] <= '0;
        end else if (match[c] && (NON_OVERLAP != 0)) begin
          blk_cnt[c] <= BLK_LOAD;
        end else if (sin_valid && (blk_cnt[c] != '0)) begin
          blk_cnt[c] <= blk_cnt[c] - BLK_W'(1);
        end
      end
    end
  end

  // Registered match outputs and counter readback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit     <= '0;
      hit_any <= 1'b0;
      hit_idx <= '0;
      cnt_q   <= '0;
    end else begin
      hit     <= match;
      hit_any <= |match;
      hit_idx <= match_idx;
      cnt_q   <= cnt_sel_val;
    end
  end

  // Saturating hit counters driven by the registered hit pulse; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) hit_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cnt_clr && (32'(cnt_sel) == c)) begin
          hit_cnt[c] <= '0;
        end else if (hit[c] && (hit_cnt[c] != '1)) begin
          hit_cnt[c] <= hit_cnt[c] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sequence_matcher_nch.sv
// tb/tb_sequence_matcher_nch.sv - scoreboard bench for sequence_matcher_nch
`timescale 1ns/1ps
module tb_sequence_matcher_nch;

  logic       clk = 1'b0;
  logic       rst, sin, sin_valid, flush, cfg_we, cfg_en, cnt_clr;
  logic [2:0] cfg_ch, cnt_sel;
  logic [7:0] cfg_pattern, cfg_mask;

  logic [3:0]  hit_a, hit_b;
  logic        any_a, any_b;
  logic [2:0]  idx_a, idx_b;
  logic [1:0]  cnt_a;
  logic [15:0] cnt_b;

  always #5 clk = ~clk;

  sequence_matcher_nch #(.WIDTH(8), .NCH(4), .CNT_W(2), .NON_OVERLAP(0)) dut_a (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .flush(flush),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_en(cfg_en), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr),
    .hit(hit_a), .hit_any(any_a), .hit_idx(idx_a), .cnt_q(cnt_a)
  );

  sequence_matcher_nch #(.WIDTH(8), .NCH(4), .CNT_W(16), .NON_OVERLAP(1)) dut_b (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .flush(flush),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_en(cfg_en), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr),
    .hit(hit_b), .hit_any(any_b), .hit_idx(idx_b), .cnt_q(cnt_b)
  );

  typedef struct packed {
    logic [3:0]  hit;
    logic        any;
    logic [2:0]  idx;
    logic [15:0] cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   obs [2][4];
  bit   saw_both;

  // reference model state: bit stream position, last 8 bits, config, last hit position per channel
  int         bits;
  logic [7:0] win;
  logic [7:0] m_pat [4];
  logic [7:0] m_msk [4];
  bit         m_en  [4];
  int         lastp [2][4];
  int         m_cnt [2][4];
  logic [3:0] phit  [2];
  int         cnt_max [2] = '{3, 65535};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    bits = 0;
    win  = 8'h00;
    for (int c = 0; c < 4; c++) begin
      m_pat[c] = 8'h00;
      m_msk[c] = 8'hFF;
      m_en[c]  = 1'b0;
    end
    for (int n = 0; n < 2; n++) begin
      phit[n] = 4'h0;
      for (int c = 0; c < 4; c++) begin
        lastp[n][c] = -100;
        m_cnt[n][c] = 0;
      end
    end
  endtask

  // evaluate the model for the coming edge, queue expectations, advance one cycle
  task automatic cyc();
    exp_t       e;
    logic [3:0] m;
    logic [7:0] wn;
    int         nb, sel, ch;
    nb  = bits + 1;
    wn  = {win[6:0], sin};
    sel = int'(cnt_sel);
    for (int n = 0; n < 2; n++) begin
      m = 4'h0;
      if (!rst && sin_valid && !flush && nb >= 8) begin
        for (int c = 0; c < 4; c++) begin
          if (m_en[c] && ((wn ^ m_pat[c]) & m_msk[c]) == 8'h00 &&
              !(n == 1 && (nb - lastp[n][c]) < 8))
            m[c] = 1'b1;
        end
      end
      e.hit = m;
      e.any = |m;
      e.idx = 3'd0;
      for (int c = 3; c >= 0; c--) if (m[c]) e.idx = 3'(c);
      e.cnt = (rst || sel > 3) ? 16'd0 : 16'(m_cnt[n][sel]);
      for (int c = 0; c < 4; c++) begin
        if (rst) m_cnt[n][c] = 0;
        else if (cnt_clr && sel == c) m_cnt[n][c] = 0;
        else if (phit[n][c] && m_cnt[n][c] < cnt_max[n]) m_cnt[n][c]++;
        if (m[c]) lastp[n][c] = nb;
      end
      phit[n] = m;
      if (n == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
    if (rst) begin
      model_reset();
    end else begin
      if (flush) begin
        bits = 0;
        win  = 8'h00;
        for (int n = 0; n < 2; n++) for (int c = 0; c < 4; c++) lastp[n][c] = -100;
      end else if (sin_valid) begin
        bits = nb;
        win  = wn;
      end
      if (cfg_we && cfg_ch < 3'd4) begin
        ch = int'(cfg_ch);
        m_pat[ch] = cfg_pattern;
        m_msk[ch] = cfg_mask;
        m_en[ch]  = cfg_en;
        for (int n = 0; n < 2; n++) lastp[n][ch] = -100;
      end
    end
    @(negedge clk);
    cfg_we  = 1'b0;
    flush   = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic send(input bit b, input int gap);
    sin = b;
    sin_valid = 1'b1;
    cyc();
    sin_valid = 1'b0;
    repeat (gap) begin
      sin = 1'($urandom);
      cyc();
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send(v[i], gap);
  endtask

  task automatic cfg(input int ch, input logic [7:0] p, input logic [7:0] m, input bit e);
    cfg_we = 1'b1;
    cfg_ch = 3'(ch);
    cfg_pattern = p;
    cfg_mask = m;
    cfg_en = e;
    cyc();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
  endtask

  task automatic clear_obs();
    for (int n = 0; n < 2; n++) for (int c = 0; c < 4; c++) obs[n][c] = 0;
    saw_both = 1'b0;
  endtask

  // monitor: compares every presented output tuple against the queued expectation
  initial begin
    exp_t act;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        act = {hit_a, any_a, idx_a, 14'd0, cnt_a};
        chk("out_a", 64'(act), 64'(e));
        for (int c = 0; c < 4; c++) if (hit_a[c] === 1'b1) obs[0][c]++;
        if (hit_a === 4'b0011 && idx_a === 3'd0) saw_both = 1'b1;
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        act = {hit_b, any_b, idx_b, cnt_b};
        chk("out_b", 64'(act), 64'(e));
        for (int c = 0; c < 4; c++) if (hit_b[c] === 1'b1) obs[1][c]++;
      end
    end
  end

  initial begin
    logic [7:0] r1, r2;
    int g_a3, g_b3;
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; flush = 1'b0; cfg_we = 1'b0;
    cfg_ch = 3'd0; cfg_pattern = 8'h00; cfg_mask = 8'h00; cfg_en = 1'b0;
    cnt_sel = 3'd0; cnt_clr = 1'b0;
    model_reset();
    clear_obs();
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // single exact pattern
    cfg(0, 8'h0F, 8'hFF, 1'b1);
    clear_obs();
    send_byte(8'h0F, 0);
    idle(3);
    chk("r035_hit_a", obs[0][0], 1);
    chk("r035_hit_b", obs[1][0], 1);
    chk("r035_cnt_a", cnt_a, 1);

    // masked channel and simultaneous hit on two channels
    cfg(1, 8'hA5, 8'hF0, 1'b1);
    cfg(0, 8'hAF, 8'hFF, 1'b1);
    clear_obs();
    send_byte(8'hAF, 0);
    idle(2);
    chk("r036_both", saw_both, 1);
    chk("r036_ch1", obs[0][1], 1);

    // overlap vs non-overlap on a run of ones
    do_flush();
    cfg(0, 8'h00, 8'hFF, 1'b0);
    cfg(1, 8'h00, 8'hFF, 1'b0);
    cfg(2, 8'hFF, 8'hFF, 1'b1);
    clear_obs();
    repeat (12) send(1'b1, 0);
    idle(2);
    chk("r037_ovl", obs[0][2], 5);
    chk("r037_novl", obs[1][2], 1);
    repeat (4) send(1'b1, 0);
    idle(2);
    chk("r037_novl16", obs[1][2], 2);

    // gapped stream equals gapless stream; flush restarts the fill
    do_flush();
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    cfg(2, 8'h00, 8'h00, 1'b1);
    cfg(3, 8'($urandom), 8'hF0, 1'b1);
    clear_obs();
    send_byte(r1, 0);
    send_byte(r2, 0);
    idle(2);
    g_a3 = obs[0][3];
    g_b3 = obs[1][3];
    chk("r038_nomask_a", obs[0][2], 9);
    chk("r038_nomask_b", obs[1][2], 2);
    do_flush();
    clear_obs();
    send_byte(r1, 3);
    send_byte(r2, 3);
    idle(2);
    chk("r038_gap_a", obs[0][2], 9);
    chk("r038_gap_b", obs[1][2], 2);
    chk("r038_gap_a3", obs[0][3], 64'(g_a3));
    chk("r038_gap_b3", obs[1][3], 64'(g_b3));
    do_flush();
    clear_obs();
    repeat (5) send(1'($urandom), 0);
    do_flush();
    repeat (7) send(1'($urandom), 0);
    idle(2);
    chk("r038_flush_none", obs[0][2], 0);
    send(1'($urandom), 0);
    idle(2);
    chk("r038_flush_a", obs[0][2], 1);
    chk("r038_flush_b", obs[1][2], 1);

    // saturation and clear against a coincident hit
    cnt_sel = 3'd2;
    cnt_clr = 1'b1;
    cyc();
    repeat (5) send(1'b1, 0);
    idle(3);
    chk("r039_sat", cnt_a, 3);
    sin = 1'b1;
    sin_valid = 1'b1;
    cyc();
    sin_valid = 1'b0;
    cnt_clr = 1'b1;
    cyc();
    idle(2);
    chk("r039_clr", cnt_a, 0);

    // reset in the middle of a window
    repeat (5) send(1'b1, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    clear_obs();
    cfg(0, 8'h00, 8'h00, 1'b1);
    repeat (7) send(1'b1, 0);
    idle(2);
    chk("r040_early", obs[0][0], 0);
    send(1'b1, 0);
    idle(2);
    chk("r040_hit_a", obs[0][0], 1);
    chk("r040_hit_b", obs[1][0], 1);
    chk("r040_en_clr", obs[0][2], 0);

    // randomized traffic
    for (int c = 0; c < 4; c++) cfg(c, 8'($urandom), 8'($urandom & $urandom & $urandom), 1'b1);
    for (int i = 0; i < 1500; i++) begin
      sin = 1'($urandom);
      sin_valid = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      cnt_sel = 3'($urandom);
      cnt_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 19) == 0) begin
        cfg_we = 1'b1;
        cfg_ch = 3'($urandom);
        cfg_pattern = 8'($urandom);
        cfg_mask = 8'($urandom & $urandom & $urandom);
        cfg_en = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      cyc();
      rst = 1'b0;
    end
    idle(2);
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sequence_matcher_nch.md
SEQUENCE_MATCHER_NCH -- requirements
Module: sequence_matcher_nch

Interface
REQ-001 SHALL have parameter WIDTH, default 8, match window length in bits (legal 2..32).
REQ-002 SHALL have parameter NCH, default 4, number of independent match channels (legal 1..8).
REQ-003 SHALL have parameter CNT_W, default 16, per-channel hit-counter width.
REQ-004 SHALL have parameter NON_OVERLAP, default 0, 1 = suppress overlapping hits per channel.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port sin  input  1  serial data bit.
REQ-008 SHALL have port sin_valid  input  1  sin qualifier; bit consumed only when high.
REQ-009 SHALL have port flush  input  1  clear window history.
REQ-010 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-011 SHALL have port cfg_ch  input  3  channel index for write.
REQ-012 SHALL have port cfg_pattern  input  WIDTH  pattern; newest bit at LSB.
REQ-013 SHALL have port cfg_mask  input  WIDTH  1 = compare bit, 0 = don't care.
REQ-014 SHALL have port cfg_en  input  1  channel enable.
REQ-015 SHALL have port cnt_sel  input  3  counter read select.
REQ-016 SHALL have port cnt_clr  input  1  clear counter of channel cnt_sel.
REQ-017 SHALL have port hit  output  NCH  per-channel one-cycle match pulse.
REQ-018 SHALL have port hit_any  output  1  OR of hit.
REQ-019 SHALL have port hit_idx  output  3  lowest index with hit set; 0 when none.
REQ-020 SHALL have port cnt_q  output  CNT_W  counter of channel cnt_sel.

Function
REQ-021 SHALL keep a WIDTH-1 bit history; window = {history, sin}, sin at LSB; history shifts only when sin_valid=1.
REQ-022 SHALL keep a fill counter (0..WIDTH, saturating) incremented per valid bit; no channel matches while the count including the current bit is < WIDTH.
REQ-023 SHALL declare channel c matching when sin_valid=1, enabled, window filled, and ((window XOR pattern_c) AND mask_c) == 0.
REQ-024 SHALL register hit: match in cycle N -> hit[c]=1 in cycle N+1 only; hit_any, hit_idx registered identically.
REQ-025 SHALL, with NON_OVERLAP=1, block channel c for the WIDTH-1 valid bits after its match; blocking is per-channel, counted in valid bits.
REQ-026 SHALL apply cfg write (cfg_ch < NCH) at clock edge; new settings govern the next valid bit after the write cycle; cfg_ch >= NCH writes ignored.
REQ-027 SHALL clear channel's non-overlap block on any cfg write to that channel.
REQ-028 SHALL increment counter c on each registered hit[c], saturating at 2^CNT_W-1 (no wrap).
REQ-029 SHALL give cnt_clr priority over a same-cycle increment of that channel: counter becomes 0.
REQ-030 SHALL register cnt_q: value of counter cnt_sel one cycle later; cnt_sel >= NCH -> cnt_q=0.
REQ-031 SHALL, on flush, zero history, fill count and all non-overlap blocks; flush with sin_valid=1 discards that bit; patterns, masks, enables, counters kept.
REQ-032 SHALL permit all-zero mask: enabled channel then hits on every valid bit once filled (subject to REQ-025).

Reset
REQ-033 SHALL on rst clear history, fill count, blocks, counters, hit, hit_any, hit_idx, cnt_q to 0; patterns 0; masks all ones; enables 0.
REQ-034 SHALL abort any in-progress window on rst mid-stream; matching resumes only after WIDTH new valid bits.

Verification
REQ-035 SHALL test: WIDTH=8, ch0 pattern 8'h0F mask 8'hFF en; bits 0,0,0,0,1,1,1,1 valid -> hit[0]=1 one cycle after 8th bit, hit_idx=0, cnt 1.
REQ-036 SHALL test: ch1 pattern 8'hA5 mask 8'hF0; stream ...1010xxxx -> hit[1]; ch0 and ch1 both match -> hit=4'b0011, hit_idx=0.
REQ-037 SHALL test: NON_OVERLAP=1, pattern 8'hFF, 12 consecutive ones -> hits after bits 8 only (next eligible bit 16); NON_OVERLAP=0 -> hits after bits 8..12.
REQ-038 SHALL test: sin_valid gaps of 3 cycles between bits -> identical hit count to gapless stream; flush after 5 bits -> no hit until 8 more valid bits.
REQ-039 SHALL test: CNT_W=2, 5 hits -> cnt_q=3; cnt_clr coincident with hit -> cnt_q=0 next cycle.
REQ-040 SHALL test: rst asserted mid-window then released -> all outputs 0, enables 0, no hit after re-enable until 8 fresh valid bits.
